tdm_demux_4ch: RTL

- Four-channel time-division demultiplexer, the receive-side counterpart of the 4:1 channel mux.
- Accepts a serial stream of WIDTH-bit beats with a start-of-frame marker on channel 0. Collects one beat per channel into an assembly buffer.
- Presents each complete 4-channel frame in parallel on a valid/ready output.
- Double-buffered (assembly + output register), so input streams back-to-back while the consumer holds a frame.

---
 rtl/tdm_demux_4ch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tdm_demux_4ch
//
// Four-channel time-division demultiplexer. A serial stream of WIDTH-bit beats
// (channel 0 flagged by in_sof) is collected into a four-slot assembly buffer.
// Each complete frame is presented in parallel on a valid/ready output
// register. The assembly buffer and the output register form a double buffer,
// so input keeps streaming while the consumer holds a frame.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   input beat present
//   in_sof     beat is channel 0 (start of frame), qualified by in_valid
//   in_data    sample data
//   in_ready   block can accept a beat this cycle (low only while FULL)
//   s1, s0     registered channel index the next accepted beat is written to
//   out_valid  parallel frame valid
//   out_ready  consumer accepts the frame
//   ch_a..ch_d channel 0..3 samples of the presented frame
//   frame_err  one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module tdm_demux_4ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             s1,
    output logic             s0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ch_a,
    output logic [WIDTH-1:0] ch_b,
    output logic [WIDTH-1:0] ch_c,
    output logic [WIDTH-1:0] ch_d,
    output logic             frame_err
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_FULL    = 2'd3
    } state_t;

    state_t           state_q;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic [WIDTH-1:0] asm_q [4];
    logic [WIDTH-1:0] out_q [4];
    logic             out_valid_q;
    logic             frame_err_q;

    logic accept;
    logic xfer;

    assign in_ready = (state_q != ST_FULL);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    // Never wraps inside a frame: the slot-3 beat leaves COLLECT.
    assign idx_d    = idx_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            idx_q       <= 2'd0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                asm_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            frame_err_q <= 1'b0;
            // A transfer empties the output register unless a new frame is
            // loaded on the same edge further down (which overrides this).
            if (xfer) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_HUNT: begin
                    if (accept && in_sof) begin
                        asm_q[0] <= in_data;
                        idx_q    <= 2'd1;
                        state_q  <= ST_COLLECT;
                    end
                end

                ST_SYNC: begin
                    if (accept) begin
                        if (in_sof) begin
                            asm_q[0] <= in_data;
                            idx_q    <= 2'd1;
                            state_q  <= ST_COLLECT;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_HUNT;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (accept) begin
                        if (in_sof) begin
                            // Index is always 1..3 here, so an sof is a resync:
                            // drop the partial frame and restart at slot 0.
                            frame_err_q <= 1'b1;
                            asm_q[0]    <= in_data;
                            idx_q       <= 2'd1;
                        end else begin
                            asm_q[idx_q] <= in_data;
                            if (idx_q == 2'd3) begin
                                idx_q <= 2'd0;
                                if (!out_valid_q || out_ready) begin
                                    // Bypass the buffer for slot 3 so the frame
                                    // appears one cycle after its last beat.
                                    out_q[0]    <= asm_q[0];
                                    out_q[1]    <= asm_q[1];
                                    out_q[2]    <= asm_q[2];
                                    out_q[3]    <= in_data;
                                    out_valid_q <= 1'b1;
                                    state_q     <= ST_SYNC;
                                end else begin
                                    state_q <= ST_FULL;
                                end
                            end else begin
                                idx_q <= idx_d;
                            end
                        end
                    end
                end

                ST_FULL: begin
                    if (xfer) begin
                        for (int i = 0; i < 4; i++) begin
                            out_q[i] <= asm_q[i];
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= ST_SYNC;
                    end
                end

                default: begin
                    state_q <= ST_HUNT;
                    idx_q   <= 2'd0;
                end
            endcase
        end
    end

    assign s1        = idx_q[1];
    assign s0        = idx_q[0];
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign ch_a      = out_q[0];
    assign ch_b      = out_q[1];
    assign ch_c      = out_q[2];
    assign ch_d      = out_q[3];

endmodule
